// File: rtl/cam_vga_pkg.sv
// Shared definitions for the camera capture -> frame buffer -> VGA path.
// Holds the default frame geometry, the frame buffer address and pixel widths,
// the RGB444 field layout and the capture FSM state encoding.
package cam_vga_pkg;

  localparam int H_PIXELS_DEF = 640;
  localparam int V_LINES_DEF  = 480;
  localparam int ADDR_W_DEF   = 19;
  localparam int PIX_W        = 12;
  localparam int BYTE_W       = 8;

  // Frame buffer word: {R,G,B} nibbles, R in the top nibble.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VBLANK  = 2'd1,
    ACTIVE  = 2'd2,
    SKIP    = 2'd3
  } cap_state_t;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } byte_phase_t;

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera-side and frame-buffer-side signals of the capture block.
//   master : camera/stimulus side (drives capture_en and the camera bus,
//            observes the frame buffer write port and status)
//   slave  : ov7670_capture itself
// Signals: capture_en, cam_vsync, cam_href, cam_data[7:0],
//          frame_addr[ADDR_W-1:0], frame_pixel[11:0], frame_we,
//          frame_done, overflow.
interface ov7670_capture_if #(
  parameter int ADDR_W = cam_vga_pkg::ADDR_W_DEF
) ();

  logic                           capture_en;
  logic                           cam_vsync;
  logic                           cam_href;
  logic [cam_vga_pkg::BYTE_W-1:0] cam_data;
  logic [ADDR_W-1:0]              frame_addr;
  logic [cam_vga_pkg::PIX_W-1:0]  frame_pixel;
  logic                           frame_we;
  logic                           frame_done;
  logic                           overflow;

  modport master (
    output capture_en, cam_vsync, cam_href, cam_data,
    input  frame_addr, frame_pixel, frame_we, frame_done, overflow
  );

  modport slave (
    input  capture_en, cam_vsync, cam_href, cam_data,
    output frame_addr, frame_pixel, frame_we, frame_done, overflow
  );

endinterface

// File: rtl/ov7670_capture_rgb565_to_rgb444.sv
// rgb565_to_rgb444: combinational conversion of one RGB565 byte pair
// (hi byte first on the camera bus) to a 12-bit RGB444 frame buffer word by
// keeping the four MSBs of each colour field.
// Ports: hi_byte[7:0], lo_byte[7:0] in; pixel[11:0] out.
module rgb565_to_rgb444
  import cam_vga_pkg::*;
(
  input  logic [BYTE_W-1:0] hi_byte,
  input  logic [BYTE_W-1:0] lo_byte,
  output logic [PIX_W-1:0]  pixel
);

  rgb444_t px;

  // RGB565 layout: hi = R4..R0 G5..G3, lo = G2..G0 B4..B0.
  always_comb begin
    px.r = hi_byte[7:4];
    px.g = {hi_byte[2:0], lo_byte[7]};
    px.b = lo_byte[4:1];
  end

  assign pixel = px;

  // Colour LSBs are intentionally discarded.
  logic unused_lsbs;
  assign unused_lsbs = &{1'b0, hi_byte[3], lo_byte[6:5], lo_byte[0]};

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: turns the OV7670 RGB565 byte stream into RGB444 pixels and
// writes them linearly into the frame buffer, one frame_we per pixel.
// Capture is frame-granular: capture_en is looked at only when vsync falls.
// Ports: pclk, rst (async, active-high), cam (ov7670_capture_if.slave):
//   capture_en, cam_vsync, cam_href, cam_data in;
//   frame_addr, frame_pixel, frame_we, frame_done, overflow out.
module ov7670_capture
  import cam_vga_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic            pclk,
  input  logic            rst,
  ov7670_capture_if.slave cam
);

  // One extra bit so the cap value is representable even when it equals
  // 2**ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(H_PIXELS * V_LINES);

  logic              vs_r, vs_d, href_r;
  logic [BYTE_W-1:0] d_r, hi_byte;
  cap_state_t        state_q, state_d;
  byte_phase_t       phase_q;
  logic [CNT_W-1:0]  addr_cnt;
  logic              vs_rise, vs_fall;
  logic              frame_start, frame_end, pair_done;
  logic [PIX_W-1:0]  pixel_c;
  logic [ADDR_W-1:0] frame_addr_q;
  logic [PIX_W-1:0]  frame_pixel_q;
  logic              frame_we_q, frame_done_q, overflow_q;

  // ---- input stage: one register on every camera input ----
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_r   <= 1'b0;
      vs_d   <= 1'b0;
      href_r <= 1'b0;
    end else begin
      vs_r   <= cam.cam_vsync;
      vs_d   <= vs_r;
      href_r <= cam.cam_href;
    end
  end

  always_ff @(posedge pclk) begin
    d_r <= cam.cam_data;
  end

  assign vs_rise = vs_r & ~vs_d;
  assign vs_fall = ~vs_r & vs_d;

  // ---- frame FSM ----
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state_q <= WAIT_VS;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pair_done   = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_r) state_d = VBLANK;
      VBLANK: begin
        if (vs_fall) begin
          frame_start = 1'b1;
          state_d     = cam.capture_en ? ACTIVE : SKIP;
        end
      end
      ACTIVE: begin
        // vsync rising takes priority over a byte arriving the same cycle.
        if (vs_rise) begin
          frame_end = 1'b1;
          state_d   = VBLANK;
        end else if (href_r && phase_q == PH_SECOND) begin
          pair_done = 1'b1;
        end
      end
      SKIP: if (vs_rise) state_d = VBLANK;
      default: state_d = WAIT_VS;
    endcase
  end

  // ---- byte pairing: any gap in href restarts at the high byte ----
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_FIRST;
    end else if (state_q == ACTIVE && href_r && !vs_rise && phase_q == PH_FIRST) begin
      phase_q <= PH_SECOND;
    end else begin
      phase_q <= PH_FIRST;
    end
  end

  always_ff @(posedge pclk) begin
    if (href_r && phase_q == PH_FIRST) hi_byte <= d_r;
  end

  rgb565_to_rgb444 u_conv (
    .hi_byte (hi_byte),
    .lo_byte (d_r),
    .pixel   (pixel_c)
  );

  // ---- write port: strobe one cycle per accepted pixel, hold data otherwise ----
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      addr_cnt      <= '0;
      overflow_q    <= 1'b0;
      frame_we_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_addr_q  <= '0;
      frame_pixel_q <= '0;
    end else begin
      frame_we_q   <= 1'b0;
      frame_done_q <= frame_end;
      if (frame_start) begin
        addr_cnt   <= '0;
        overflow_q <= 1'b0;
      end else if (pair_done) begin
        if (addr_cnt == FRAME_PIX) begin
          overflow_q <= 1'b1;
        end else begin
          frame_we_q    <= 1'b1;
          frame_addr_q  <= addr_cnt[ADDR_W-1:0];
          frame_pixel_q <= pixel_c;
          addr_cnt      <= addr_cnt + 1'b1;
        end
      end
    end
  end

  assign cam.frame_addr  = frame_addr_q;
  assign cam.frame_pixel = frame_pixel_q;
  assign cam.frame_we    = frame_we_q;
  assign cam.frame_done  = frame_done_q;
  assign cam.overflow    = overflow_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 8x4 frame so full, ragged and
// oversized frames stay short. Expected writes are queued as bytes are driven
// and popped as frame_we strobes appear.
module tb_ov7670_capture;

  localparam int H      = 8;
  localparam int V      = 4;
  localparam int AW     = 19;
  localparam int CAP    = H * V;
  localparam int LINE_B = 2 * H;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  ov7670_capture_if #(.ADDR_W(AW)) cam ();

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .pclk (pclk),
    .rst  (rst),
    .cam  (cam)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  logic [AW+11:0] exp_q[$];
  logic [7:0]     line_q[$];
  bit             model_cap = 1'b0;
  int             model_cnt = 0;
  bit             model_ovf = 1'b0;
  int             done_exp  = 0;
  int             done_seen = 0;
  int             last_byte_cyc = 0;
  int             last_we_cyc   = -1;
  logic           prev_we = 1'b0;

  // RGB565 fields reduced to their top four bits.
  function automatic logic [11:0] conv(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    return {r5[4:1], g6[5:2], b5[4:1]};
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic monitor();
    logic [AW+11:0] e;
    forever begin
      @(negedge pclk);
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        if (cam.frame_done === 1'b1) done_seen++;
        if (cam.frame_we === 1'b1) begin
          last_we_cyc = cyc;
          checks++;
          if (prev_we !== 1'b0) begin
            failures++;
            $display("FAIL we_width: frame_we high on consecutive cycles at addr=%0d", cam.frame_addr);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: addr=%0d pixel=%h, expected no write", cam.frame_addr, cam.frame_pixel);
          end else begin
            e = exp_q.pop_front();
            if ({cam.frame_addr, cam.frame_pixel} !== e)
              begin
                failures++;
                $display("FAIL write_data: got addr=%0d pixel=%h, expected addr=%0d pixel=%h",
                         cam.frame_addr, cam.frame_pixel, e[AW+11:12], e[11:0]);
              end
          end
        end
        prev_we = cam.frame_we;
      end
    end
  endtask

  task automatic send_line(input int nbytes, input bit use_q);
    logic [7:0] b;
    logic [7:0] hi;
    hi = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = use_q ? line_q.pop_front() : 8'($urandom_range(0, 255));
      tick();
      cam.cam_href = 1'b1;
      cam.cam_data = b;
      last_byte_cyc = cyc;
      if (i % 2 == 0) begin
        hi = b;
      end else if (model_cap) begin
        if (model_cnt < CAP) begin
          exp_q.push_back({AW'(model_cnt), conv(hi, b)});
          model_cnt++;
        end else begin
          model_ovf = 1'b1;
        end
      end
    end
    tick();
    cam.cam_href = 1'b0;
    cam.cam_data = 8'h00;
    repeat (3) tick();
  endtask

  task automatic frame_start(input bit en);
    tick();
    cam.cam_vsync  = 1'b1;
    cam.capture_en = en;
    repeat (3) tick();
    cam.cam_vsync = 1'b0;
    model_cap = en;
    model_cnt = 0;
    model_ovf = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_end();
    tick();
    cam.cam_vsync = 1'b1;
    if (model_cap) done_exp++;
    model_cap = 1'b0;
    repeat (4) tick();
    checks++;
    if (done_seen !== done_exp) begin
      failures++;
      $display("FAIL frame_done_count: got %0d, expected %0d", done_seen, done_exp);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: %0d pixels never written", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (cam.overflow !== model_ovf) begin
      failures++;
      $display("FAIL overflow_end: got %b, expected %b", cam.overflow, model_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cam.frame_addr, cam.frame_pixel, cam.frame_we, cam.frame_done, cam.overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: addr=%0d pixel=%h we=%b done=%b ovf=%b, expected all 0",
               cam.frame_addr, cam.frame_pixel, cam.frame_we, cam.frame_done, cam.overflow);
    end
    rst = 1'b0;
    frame_start(1'b1);
    send_line(LINE_B, 1'b0);
    // Reset arrives mid-line, before the second byte of a pair is registered.
    tick();
    cam.cam_href = 1'b1;
    cam.cam_data = 8'hA5;
    tick();
    cam.cam_data = 8'h5A;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cam.frame_addr, cam.frame_pixel, cam.frame_we, cam.frame_done, cam.overflow} !== '0) begin
      failures++;
      $display("FAIL async_reset: addr=%0d pixel=%h we=%b done=%b ovf=%b, expected all 0",
               cam.frame_addr, cam.frame_pixel, cam.frame_we, cam.frame_done, cam.overflow);
    end
    model_cap = 1'b0;
    tick();
    cam.cam_href = 1'b0;
    tick();
    rst = 1'b0;
    // Still waiting for vsync: a line now must not be captured.
    send_line(LINE_B, 1'b0);
    checks++;
    if (cam.frame_addr !== '0) begin
      failures++;
      $display("FAIL wait_vs_no_capture: frame_addr=%0d, expected 0", cam.frame_addr);
    end
  endtask

  task automatic test_first_pixel();
    frame_start(1'b1);
    last_we_cyc = -1;
    line_q = '{8'hF8, 8'h00};
    send_line(2, 1'b1);
    checks++;
    if (last_we_cyc - last_byte_cyc != 2) begin
      failures++;
      $display("FAIL first_latency: frame_we %0d edges after byte, expected 2", last_we_cyc - last_byte_cyc);
    end
    checks++;
    if (cam.frame_pixel !== 12'hF00 || cam.frame_addr !== '0) begin
      failures++;
      $display("FAIL red_pixel: addr=%0d pixel=%h, expected addr=0 pixel=f00", cam.frame_addr, cam.frame_pixel);
    end
    frame_end();
  endtask

  task automatic test_two_pixels();
    frame_start(1'b1);
    line_q = '{8'h07, 8'hE0, 8'h00, 8'h1F};
    send_line(4, 1'b1);
    checks++;
    if (cam.frame_pixel !== 12'h00F || cam.frame_addr !== AW'(1)) begin
      failures++;
      $display("FAIL blue_hold: addr=%0d pixel=%h, expected addr=1 pixel=00f", cam.frame_addr, cam.frame_pixel);
    end
    frame_end();
  endtask

  task automatic test_full_frame();
    frame_start(1'b1);
    repeat (V) send_line(LINE_B, 1'b0);
    checks++;
    if (cam.frame_addr !== AW'(CAP - 1)) begin
      failures++;
      $display("FAIL full_last_addr: got %0d, expected %0d", cam.frame_addr, CAP - 1);
    end
    frame_end();
  endtask

  task automatic test_odd_line();
    frame_start(1'b1);
    send_line(LINE_B + 1, 1'b0);
    repeat (V - 1) send_line(LINE_B, 1'b0);
    checks++;
    if (cam.frame_addr !== AW'(CAP - 1)) begin
      failures++;
      $display("FAIL odd_last_addr: got %0d, expected %0d", cam.frame_addr, CAP - 1);
    end
    frame_end();
  endtask

  task automatic test_overflow();
    frame_start(1'b1);
    repeat (V + 1) send_line(LINE_B, 1'b0);
    checks++;
    if (cam.frame_addr !== AW'(CAP - 1)) begin
      failures++;
      $display("FAIL ovf_last_addr: got %0d, expected %0d", cam.frame_addr, CAP - 1);
    end
    frame_end();
    frame_start(1'b1);
    checks++;
    if (cam.overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: got %b, expected 0", cam.overflow);
    end
    repeat (V) send_line(LINE_B, 1'b0);
    frame_end();
  endtask

  task automatic test_capture_disabled();
    frame_start(1'b0);
    send_line(LINE_B, 1'b0);
    cam.capture_en = 1'b1;
    repeat (V - 1) send_line(LINE_B, 1'b0);
    frame_end();
    frame_start(1'b1);
    repeat (V) send_line(LINE_B, 1'b0);
    frame_end();
  endtask

  initial begin
    cam.capture_en = 1'b0;
    cam.cam_vsync  = 1'b0;
    cam.cam_href   = 1'b0;
    cam.cam_data   = 8'h00;
    fork
      monitor();
    join_none
    test_reset();
    test_first_pixel();
    test_two_pixels();
    test_full_frame();
    test_odd_line();
    test_overflow();
    test_capture_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
Upstream stage of the VGA scan-out path. It takes the OV7670 camera's parallel byte stream (RGB565, two bytes per pixel, qualified by href and framed by vsync) and converts each pixel to RGB444. It writes the pixels linearly into the dual-port frame buffer. The VGA stage later reads that buffer with the same 19-bit linear address and 12-bit {R,G,B} nibble format.

Parameters:
H_PIXELS, 640, active pixels per line (used for the frame pixel cap)
V_LINES, 480, active lines per frame
ADDR_W, 19, frame buffer address width; must satisfy H_PIXELS*V_LINES <= 2**ADDR_W

Ports:
pclk  input  1  camera pixel clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
capture_en  input  1  frame-granular capture enable, sampled only at frame start
cam_vsync  input  1  camera vsync, active high (high = vertical blanking)
cam_href  input  1  camera href, high while line bytes are valid
cam_data  input  8  camera byte bus
frame_addr  output  ADDR_W  write address into frame buffer
frame_pixel  output  12  RGB444 write data {R[3:0],G[3:0],B[3:0]}
frame_we  output  1  write strobe, one pclk per pixel
frame_done  output  1  one-cycle pulse when a captured frame completes
overflow  output  1  sticky: more than H_PIXELS*V_LINES pixels arrived this frame

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-high, named rst.
- Reset values: frame_addr=0, frame_pixel=0, frame_we=0, frame_done=0, overflow=0, FSM=WAIT_VS, byte phase=FIRST.
- Input stage: cam_vsync, cam_href and cam_data are registered once (vs_r, href_r, d_r). All decisions use the registered copies.
- FSM states:
  - WAIT_VS: after reset. Wait for vs_r=1 so capture never starts mid-frame. Go to VBLANK.
  - VBLANK: on vs_r falling (1→0), load addr_cnt=0 and clear overflow. If capture_en=1, go to ACTIVE; otherwise go to SKIP.
  - ACTIVE: capture bytes. On vs_r rising, pulse frame_done for 1 cycle and go to VBLANK.
  - SKIP: no writes, no frame_done. On vs_r rising, go to VBLANK.
- Byte pairing in ACTIVE, on cycles with href_r=1:
  - Phase FIRST: latch d_r as hi_byte, then phase=SECOND.
  - Phase SECOND: form the pixel, then phase=FIRST.
  - href_r=0 forces phase=FIRST. A lone trailing byte is dropped with no write.
- Colour conversion: frame_pixel = {hi[7:4], hi[2:0], lo[7], lo[4:1]}. This keeps the R5, G6 and B5 MSBs.
- Write timing and latency:
  - frame_we rises on the edge after the SECOND byte is held in d_r, i.e. 2 pclk edges after the second byte is on cam_data.
  - frame_we is high for exactly 1 cycle.
  - frame_addr carries that pixel's address during the strobe. addr_cnt increments after each accepted pixel.
  - frame_addr and frame_pixel hold their last values while frame_we=0.
- Pixel cap: when addr_cnt = H_PIXELS*V_LINES, further pixels produce no frame_we and addr_cnt holds. overflow is set and stays set until the next VBLANK→ACTIVE/SKIP transition.
- Simultaneous events:
  - vs_r rising with href_r=1: vsync wins; the pending byte is dropped.
  - frame_done is emitted even if overflow=1.
- capture_en changes mid-frame have no effect until the next vsync falling edge.
- Reset mid-frame returns to WAIT_VS. Capture resumes only after a full vsync high→low sequence.

Decomposition:
- Shared package (cam_vga_pkg): H_PIXELS/V_LINES defaults, ADDR_W, pixel width 12, RGB444 field slices, FSM state encoding.
- Sub-module rgb565_to_rgb444: combinational byte pair → 12-bit pixel. The FSM, counters and input registers stay in ov7670_capture.

Test Plan:
- Reset mid-stream, then one full vsync pulse and line 0 with bytes 0xF8,0x00 (red) → first frame_we at frame_addr=0 with frame_pixel=0xF00; frame_we exactly 2 edges after byte 0x00.
- Bytes 0x07,0xE0 then 0x00,0x1F → pixels 0x0F0 at addr 0 and 0x00F at addr 1; frame_we high 1 cycle per pixel, low between them.
- Frame of 480 lines × 1280 bytes, capture_en=1 → 307200 writes, last at addr 307199; frame_done pulses once on vsync rise; overflow=0.
- Line with 1281 bytes (href drops after an odd byte) → the extra byte causes no write; the next line's first pixel lands at the correct next address.
- Frame with 481 lines → writes stop at addr 307199 and overflow=1; overflow clears at the next vsync falling edge.
- capture_en=0 at vsync fall, toggled to 1 mid-frame → no frame_we and no frame_done that frame; the next frame captures normally from addr 0.
